fifo36_rx_dispatch: RTL and testbench
=====================================

Name: fifo36_rx_dispatch

Overview:
- Sits on the sys_clk side of the GEMAC RX 2-clock FIFO and consumes its 36-bit frame stream.
- Captures the first HDR_WORDS words of each Ethernet frame and classifies the frame.
- Steers the whole frame to one of two f36 outputs: DSP for matching IPv4/UDP traffic, CPU for everything else.
- Never drops a well-formed frame and preserves byte order and occ.

Parameters:
- HDR_WORDS, 10, header words buffered before the routing decision; must be ≥10 (UDP dst port sits in word 9).

Ports:
- clk  in  1  sys_clk domain clock
- reset  in  1  asynchronous, active-high
- clear  in  1  synchronous; same effect as reset
- cfg_enable  in  1  1 = DSP routing allowed; 0 = all frames to CPU
- cfg_udp_port  in  16  UDP destination port routed to DSP
- in_data  in  36  [31:0] data, first byte in [31:24]; [32] sof; [33] eof; [35:34] occ (valid bytes in eof word, 0 = 4)
- in_src_rdy  in  1  upstream word valid
- in_dst_rdy  out  1  block accepts word
- dsp_data  out  36  DSP-bound stream, same format
- dsp_src_rdy  out  1
- dsp_dst_rdy  in  1
- cpu_data  out  36  CPU-bound stream, same format
- cpu_src_rdy  out  1
- cpu_dst_rdy  in  1
- dsp_pkt_count  out  16  frames routed to DSP, wraps 0xFFFF→0
- cpu_pkt_count  out  16  frames routed to CPU, wraps

Behaviour:
- Transfer occurs when src_rdy & dst_rdy are both high on a rising edge.
- Reset/clear: state IDLE, buffer pointers 0, counters 0, dsp_src_rdy = cpu_src_rdy = 0, in_dst_rdy = 0 for that cycle.
- Clear mid-frame truncates any output frame in flight; clear is only for quiescent use.
- States:
  - IDLE: in_dst_rdy = 1. Words without sof are discarded. A sof word is written to buf[0], wr_ptr = 1, go to CAPTURE. A word with both sof and eof is a 1-word frame: store it, go to DECIDE.
  - CAPTURE: in_dst_rdy = 1. Each word is written to buf[wr_ptr] and wr_ptr increments.
    - Go to DECIDE after the word with eof, or after buf[HDR_WORDS-1] is written.
    - A sof word here aborts the partial frame: discard the buffer, store the new word at buf[0], wr_ptr = 1, count nothing.
  - DECIDE: one cycle, in_dst_rdy = 0. Sample cfg_* here. Route = DSP only if all of the following hold; otherwise route = CPU:
    - cfg_enable = 1
    - wr_ptr == HDR_WORDS (frame is not short)
    - buf[3][31:16] = 0x0800
    - buf[3][15:8] = 0x45
    - buf[5][7:0] = 0x11
    - buf[9][31:16] = cfg_udp_port
    - Increment the matching counter. Go to REPLAY.
  - REPLAY: in_dst_rdy = 0. Selected output presents buf[rd_ptr] with src_rdy = 1; rd_ptr increments per output transfer. The unselected output has src_rdy = 0, data don't-care.
    - After the last buffered word: if it carried eof, go to IDLE; else go to PASS.
  - PASS: combinational pass-through. sel_data = in_data, sel_src_rdy = in_src_rdy, in_dst_rdy = sel_dst_rdy. Go to IDLE after the eof transfer.
    - A sof word in PASS is forwarded as data with eof forced on the previous frame impossible, so it is dropped: in_dst_rdy = 1 for that word, not forwarded, state → CAPTURE with the word stored at buf[0].
- Latency: header words accepted on cycles 0..HDR_WORDS-1, DECIDE on cycle HDR_WORDS, first output word valid on cycle HDR_WORDS+1. Short frame with eof at word k: first output on cycle k+2.
- Throughput in PASS: 1 word/clk. Header overhead: HDR_WORDS+1 input-stall cycles per frame.
- occ and eof bits are copied unchanged; sof is forwarded on the first output word only.
- Backpressure: output dst_rdy low holds rd_ptr (REPLAY) or stalls input (PASS). Output data is stable while src_rdy is high and not accepted.

Test Plan:
- 16-word IPv4/UDP frame, ethertype 0x0800, 0x45, proto 0x11, dst port 0x1234, cfg_udp_port = 0x1234, enable = 1 → 16 words on dsp identical to input, first dsp word valid cycle 11, dsp_pkt_count = 1, cpu_src_rdy never high.
- Same frame with cfg_udp_port = 0x1235, then again with cfg_enable = 0 → both frames on cpu, cpu_pkt_count = 2.
- ARP frame (0x0806, 15 words, last occ = 2) → cpu, occ = 2 on eof word. 4-word frame with eof at word 3 → cpu, first cpu word on cycle 5.
- Random dsp_dst_rdy/cpu_dst_rdy at 50% duty and in_src_rdy at 70% over 200 mixed frames → every output stream matches the scoreboard, no lost or duplicated words, counts sum to 200.
- Stray non-sof words in IDLE, then sof at word 4 of a partial capture → strays discarded, only the restarted frame emitted, counters increment once.
- Assert reset during PASS of a DSP frame → outputs src_rdy = 0 immediately, counters 0. The next frame after reset is routed correctly.

Source files
------------

// File: rtl/fifo36_rx_dispatch.sv
// rtl/fifo36_rx_dispatch.sv - classify RX f36 frames on their header and steer each whole frame to DSP or CPU
module fifo36_rx_dispatch #(
    parameter int HDR_WORDS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        cfg_enable,
    input  logic [15:0] cfg_udp_port,
    input  logic [35:0] in_data,
    input  logic        in_src_rdy,
    output logic        in_dst_rdy,
    output logic [35:0] dsp_data,
    output logic        dsp_src_rdy,
    input  logic        dsp_dst_rdy,
    output logic [35:0] cpu_data,
    output logic        cpu_src_rdy,
    input  logic        cpu_dst_rdy,
    output logic [15:0] dsp_pkt_count,
    output logic [15:0] cpu_pkt_count
);
    localparam int PW = $clog2(HDR_WORDS + 1);
    localparam logic [PW-1:0] LAST_HDR = PW'(HDR_WORDS - 1);
    localparam logic [PW-1:0] FULL_HDR = PW'(HDR_WORDS);

    typedef enum logic [2:0] {IDLE, CAPTURE, DECIDE, REPLAY, PASS} state_t;

    state_t        state;
    logic [35:0]   hdr_buf [HDR_WORDS];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          route_dsp;

    logic          in_sof;
    logic          in_eof;
    logic          in_xfer;
    logic          sel_src_rdy;
    logic          sel_dst_rdy;
    logic          sel_xfer;
    logic [35:0]   sel_data;
    logic          hdr_match;
    logic          buf_we;
    logic [PW-1:0] buf_idx;

    assign in_sof      = in_data[32];
    assign in_eof      = in_data[33];
    assign sel_dst_rdy = route_dsp ? dsp_dst_rdy : cpu_dst_rdy;

    // A sof seen in PASS is swallowed and restarts capture rather than being forwarded.
    always_comb begin
        in_dst_rdy  = 1'b0;
        sel_src_rdy = 1'b0;
        sel_data    = hdr_buf[rd_ptr];
        case (state)
            IDLE, CAPTURE: in_dst_rdy = 1'b1;
            REPLAY:        sel_src_rdy = 1'b1;
            PASS: begin
                sel_data    = in_data;
                sel_src_rdy = in_src_rdy & ~in_sof;
                in_dst_rdy  = in_sof | sel_dst_rdy;
            end
            default: ;
        endcase
        if (reset || clear) begin
            in_dst_rdy  = 1'b0;
            sel_src_rdy = 1'b0;
        end
    end

    assign in_xfer     = in_src_rdy & in_dst_rdy;
    assign sel_xfer    = sel_src_rdy & sel_dst_rdy;
    assign dsp_src_rdy = sel_src_rdy & route_dsp;
    assign cpu_src_rdy = sel_src_rdy & ~route_dsp;
    assign dsp_data    = sel_data;
    assign cpu_data    = sel_data;

    // Ethertype IPv4, version/IHL 0x45, protocol UDP, then the UDP destination port.
    assign hdr_match = cfg_enable && (wr_ptr == FULL_HDR)
                    && (hdr_buf[3][31:16] == 16'h0800)
                    && (hdr_buf[3][15:8] == 8'h45)
                    && (hdr_buf[5][7:0] == 8'h11)
                    && (hdr_buf[9][31:16] == cfg_udp_port);

    always_comb begin
        buf_we  = 1'b0;
        buf_idx = wr_ptr;
        if (in_xfer) begin
            if (in_sof && (state == IDLE || state == CAPTURE || state == PASS)) begin
                buf_we  = 1'b1;
                buf_idx = '0;
            end else if (state == CAPTURE) begin
                buf_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            hdr_buf[buf_idx] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            route_dsp     <= 1'b0;
            dsp_pkt_count <= '0;
            cpu_pkt_count <= '0;
        end else if (clear) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            route_dsp     <= 1'b0;
            dsp_pkt_count <= '0;
            cpu_pkt_count <= '0;
        end else begin
            case (state)
                IDLE, CAPTURE, PASS: begin
                    if (in_xfer && in_sof) begin
                        wr_ptr <= PW'(1);
                        state  <= in_eof ? DECIDE : CAPTURE;
                    end else if (in_xfer && state == CAPTURE) begin
                        wr_ptr <= wr_ptr + PW'(1);
                        if (in_eof || wr_ptr == LAST_HDR) begin
                            state <= DECIDE;
                        end
                    end else if (in_xfer && state == PASS && in_eof) begin
                        state <= IDLE;
                    end
                end
                DECIDE: begin
                    route_dsp <= hdr_match;
                    rd_ptr    <= '0;
                    state     <= REPLAY;
                    if (hdr_match) begin
                        dsp_pkt_count <= dsp_pkt_count + 16'd1;
                    end else begin
                        cpu_pkt_count <= cpu_pkt_count + 16'd1;
                    end
                end
                REPLAY: begin
                    if (sel_xfer) begin
                        if (rd_ptr == wr_ptr - PW'(1)) begin
                            rd_ptr <= '0;
                            state  <= hdr_buf[rd_ptr][33] ? IDLE : PASS;
                        end else begin
                            rd_ptr <= rd_ptr + PW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo36_rx_dispatch.sv
// tb/tb_fifo36_rx_dispatch.sv - directed and randomised checks of fifo36_rx_dispatch routing
module tb_fifo36_rx_dispatch;
    logic        clk;
    logic        reset;
    logic        clear;
    logic        cfg_enable;
    logic [15:0] cfg_udp_port;
    logic [35:0] in_data;
    logic        in_src_rdy;
    logic        in_dst_rdy;
    logic [35:0] dsp_data;
    logic        dsp_src_rdy;
    logic        dsp_dst_rdy;
    logic [35:0] cpu_data;
    logic        cpu_src_rdy;
    logic        cpu_dst_rdy;
    logic [15:0] dsp_pkt_count;
    logic [15:0] cpu_pkt_count;

    fifo36_rx_dispatch #(.HDR_WORDS(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .cfg_enable    (cfg_enable),
        .cfg_udp_port  (cfg_udp_port),
        .in_data       (in_data),
        .in_src_rdy    (in_src_rdy),
        .in_dst_rdy    (in_dst_rdy),
        .dsp_data      (dsp_data),
        .dsp_src_rdy   (dsp_src_rdy),
        .dsp_dst_rdy   (dsp_dst_rdy),
        .cpu_data      (cpu_data),
        .cpu_src_rdy   (cpu_src_rdy),
        .cpu_dst_rdy   (cpu_dst_rdy),
        .dsp_pkt_count (dsp_pkt_count),
        .cpu_pkt_count (cpu_pkt_count)
    );

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          src_pct = 100;
    int          dst_pct = 100;
    int          sof_cyc = 0;
    int          last_lat = -1;
    bit          lat_armed = 0;
    int          dsp_xfer = 0;
    bit          cpu_seen = 0;
    logic [1:0]  last_cpu_occ = 2'd0;
    int          exp_dsp_cnt = 0;
    int          exp_cpu_cnt = 0;
    int          frame_no = 0;
    logic [35:0] in_q[$];
    logic [35:0] dsp_exp[$];
    logic [35:0] cpu_exp[$];

    task automatic check_vec(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    // Builds one frame, queues it for the driver, and predicts its destination.
    task automatic send_frame(input int len, input logic [15:0] etype, input logic [7:0] vihl,
                              input logic [7:0] proto, input logic [15:0] port,
                              input logic [1:0] occ, input bit complete);
        logic [35:0] w[$];
        logic [31:0] d;
        logic        last;
        bit          to_dsp;
        frame_no++;
        for (int i = 0; i < len; i++) begin
            d = {8'(frame_no), 8'(i), 16'($urandom)};
            if (i == 3) d = {etype, vihl, d[7:0]};
            if (i == 5) d[7:0] = proto;
            if (i == 9) d[31:16] = port;
            last = complete && (i == len - 1);
            w.push_back({last ? occ : 2'b00, last, (i == 0), d});
        end
        to_dsp = cfg_enable && len >= 10 && w[3][31:16] == 16'h0800 && w[3][15:8] == 8'h45
                 && w[5][7:0] == 8'h11 && w[9][31:16] == cfg_udp_port;
        foreach (w[i]) begin
            in_q.push_back(w[i]);
            if (complete && to_dsp) dsp_exp.push_back(w[i]);
            if (complete && !to_dsp) cpu_exp.push_back(w[i]);
        end
        if (complete && to_dsp) exp_dsp_cnt++;
        if (complete && !to_dsp) exp_cpu_cnt++;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((in_q.size() + dsp_exp.size() + cpu_exp.size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        check_vec(tag, 48'(in_q.size() + dsp_exp.size() + cpu_exp.size()), 48'd0);
    endtask

    task automatic check_counts(input string tag);
        check_vec({tag, "_dsp_cnt"}, 48'(dsp_pkt_count), 48'(exp_dsp_cnt));
        check_vec({tag, "_cpu_cnt"}, 48'(cpu_pkt_count), 48'(exp_cpu_cnt));
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        in_src_rdy  = 1'b0;
        in_data     = '0;
        dsp_dst_rdy = 1'b0;
        cpu_dst_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (in_q.size() > 0 && hit(src_pct)) begin
                in_data    = in_q[0];
                in_src_rdy = 1'b1;
            end else begin
                in_data    = '0;
                in_src_rdy = 1'b0;
            end
            dsp_dst_rdy = hit(dst_pct);
            cpu_dst_rdy = hit(dst_pct);
        end
    end

    // Handshakes are judged mid-cycle, where they predict the transfer at the next edge.
    initial forever begin
        logic [35:0] e;
        @(negedge clk);
        if (!reset && !clear) begin
            if (in_src_rdy && in_dst_rdy) begin
                if (in_data[32]) begin
                    sof_cyc   = cyc;
                    lat_armed = 1;
                end
                void'(in_q.pop_front());
            end
            if (dsp_src_rdy || cpu_src_rdy)
                check_vec("single_output", 48'(dsp_src_rdy & cpu_src_rdy), 48'd0);
            if (cpu_src_rdy) cpu_seen = 1;
            if (lat_armed && (dsp_src_rdy || cpu_src_rdy)) begin
                last_lat  = cyc - sof_cyc;
                lat_armed = 0;
            end
            if (dsp_src_rdy && dsp_dst_rdy) begin
                dsp_xfer++;
                check_vec("dsp_word_expected", 48'(dsp_exp.size() > 0), 48'd1);
                if (dsp_exp.size() > 0) begin
                    e = dsp_exp.pop_front();
                    check_vec("dsp_data", 48'(dsp_data), 48'(e));
                end
            end
            if (cpu_src_rdy && cpu_dst_rdy) begin
                if (cpu_data[33]) last_cpu_occ = cpu_data[35:34];
                check_vec("cpu_word_expected", 48'(cpu_exp.size() > 0), 48'd1);
                if (cpu_exp.size() > 0) begin
                    e = cpu_exp.pop_front();
                    check_vec("cpu_data", 48'(cpu_data), 48'(e));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int target;
        int base_sum;
        int kind;
        int len;
        reset        = 1'b1;
        clear        = 1'b0;
        cfg_enable   = 1'b0;
        cfg_udp_port = 16'h0000;
        repeat (3) @(posedge clk);
        #2;
        check_vec("rst_in_dst_rdy", 48'(in_dst_rdy), 48'd0);
        check_vec("rst_dsp_src_rdy", 48'(dsp_src_rdy), 48'd0);
        check_vec("rst_cpu_src_rdy", 48'(cpu_src_rdy), 48'd0);
        check_vec("rst_dsp_cnt", 48'(dsp_pkt_count), 48'd0);
        check_vec("rst_cpu_cnt", 48'(cpu_pkt_count), 48'd0);
        reset = 1'b0;
        @(posedge clk);
        #2;
        check_vec("idle_in_dst_rdy", 48'(in_dst_rdy), 48'd1);

        cfg_enable   = 1'b1;
        cfg_udp_port = 16'h1234;
        cpu_seen     = 0;
        send_frame(16, 16'h0800, 8'h45, 8'h11, 16'h1234, 2'd0, 1);
        wait_drain("udp_drain", 400);
        check_vec("udp_latency", 48'(last_lat), 48'd11);
        check_vec("udp_dsp_cnt", 48'(dsp_pkt_count), 48'd1);
        check_vec("udp_cpu_cnt", 48'(cpu_pkt_count), 48'd0);
        check_vec("udp_cpu_quiet", 48'(cpu_seen), 48'd0);

        cfg_udp_port = 16'h1235;
        send_frame(16, 16'h0800, 8'h45, 8'h11, 16'h1234, 2'd0, 1);
        wait_drain("port_drain", 400);
        cfg_udp_port = 16'h1234;
        cfg_enable   = 1'b0;
        send_frame(16, 16'h0800, 8'h45, 8'h11, 16'h1234, 2'd0, 1);
        wait_drain("disable_drain", 400);
        check_vec("miss_cpu_cnt", 48'(cpu_pkt_count), 48'd2);
        check_vec("miss_dsp_cnt", 48'(dsp_pkt_count), 48'd1);

        cfg_enable = 1'b1;
        send_frame(15, 16'h0806, 8'h00, 8'h01, 16'h0000, 2'd2, 1);
        wait_drain("arp_drain", 400);
        check_vec("arp_occ", 48'(last_cpu_occ), 48'd2);
        check_vec("arp_cpu_cnt", 48'(cpu_pkt_count), 48'd3);

        send_frame(4, 16'h0800, 8'h45, 8'h11, 16'h1234, 2'd3, 1);
        wait_drain("short_drain", 400);
        check_vec("short_latency", 48'(last_lat), 48'd5);
        check_vec("short_cpu_cnt", 48'(cpu_pkt_count), 48'd4);

        for (int i = 0; i < 3; i++) in_q.push_back({4'b0000, 16'hdead, 16'(i)});
        send_frame(4, 16'h0800, 8'h45, 8'h11, 16'h1234, 2'd0, 0);
        send_frame(12, 16'h0800, 8'h45, 8'h11, 16'h1234, 2'd1, 1);
        wait_drain("abort_drain", 400);
        check_vec("abort_dsp_cnt", 48'(dsp_pkt_count), 48'd2);
        check_vec("abort_cpu_cnt", 48'(cpu_pkt_count), 48'd4);

        src_pct  = 70;
        dst_pct  = 50;
        base_sum = int'(dsp_pkt_count) + int'(cpu_pkt_count);
        for (int f = 0; f < 200; f++) begin
            kind = $urandom_range(0, 3);
            len  = $urandom_range(1, 24);
            case (kind)
                0: send_frame(len, 16'h0800, 8'h45, 8'h11, 16'h1234, 2'($urandom), 1);
                1: send_frame(len, 16'h0800, 8'h45, 8'h11, 16'h4321, 2'($urandom), 1);
                2: send_frame(len, 16'h0806, 8'h45, 8'h11, 16'h1234, 2'($urandom), 1);
                default: send_frame(len, 16'h0800, 8'h45, 8'h06, 16'h1234, 2'($urandom), 1);
            endcase
        end
        wait_drain("rand_drain", 40000);
        check_counts("rand");
        check_vec("rand_total", 48'(int'(dsp_pkt_count) + int'(cpu_pkt_count) - base_sum), 48'd200);

        src_pct = 100;
        dst_pct = 100;
        target  = dsp_xfer + 12;
        send_frame(16, 16'h0800, 8'h45, 8'h11, 16'h1234, 2'd0, 1);
        n = 0;
        while (dsp_xfer < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        check_vec("pass_reached", 48'(dsp_xfer >= target), 48'd1);
        #1;
        check_vec("pass_dsp_active", 48'(dsp_src_rdy), 48'd1);
        reset = 1'b1;
        #1;
        check_vec("mid_rst_dsp_src_rdy", 48'(dsp_src_rdy), 48'd0);
        check_vec("mid_rst_cpu_src_rdy", 48'(cpu_src_rdy), 48'd0);
        check_vec("mid_rst_in_dst_rdy", 48'(in_dst_rdy), 48'd0);
        check_vec("mid_rst_dsp_cnt", 48'(dsp_pkt_count), 48'd0);
        check_vec("mid_rst_cpu_cnt", 48'(cpu_pkt_count), 48'd0);
        in_q.delete();
        dsp_exp.delete();
        cpu_exp.delete();
        lat_armed   = 0;
        exp_dsp_cnt = 0;
        exp_cpu_cnt = 0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        send_frame(11, 16'h0800, 8'h45, 8'h11, 16'h1234, 2'd2, 1);
        wait_drain("post_rst_drain", 400);
        check_vec("post_rst_dsp_cnt", 48'(dsp_pkt_count), 48'd1);
        check_vec("post_rst_cpu_cnt", 48'(cpu_pkt_count), 48'd0);

        @(posedge clk);
        #2;
        clear = 1'b1;
        #1;
        check_vec("clr_in_dst_rdy", 48'(in_dst_rdy), 48'd0);
        @(posedge clk);
        #1;
        check_vec("clr_dsp_cnt", 48'(dsp_pkt_count), 48'd0);
        check_vec("clr_cpu_cnt", 48'(cpu_pkt_count), 48'd0);
        clear = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
